// File: rtl/tmr_pkg.sv
// rtl/tmr_pkg.sv - shared types and helpers for the local-TMR scrub controller
//
// Purpose: FSM state and event-kind encodings plus the bitwise majority and
// 3-bit popcount helpers used by the mismatch detector and the controller.
// Ports: none (package).

package tmr_pkg;

   typedef enum logic [1:0] {
      ST_MONITOR = 2'd0,
      ST_SCRUB   = 2'd1,
      ST_CHECK   = 2'd2,
      ST_REPORT  = 2'd3
   } tmr_state_t;

   typedef enum logic [1:0] {
      EVT_CORRECTED    = 2'd0,
      EVT_PERSIST_FAIL = 2'd1,
      EVT_UNCORR       = 2'd2,
      EVT_RESERVED     = 2'd3
   } tmr_evt_kind_t;

   function automatic logic majority(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic [1:0] popcount3(input logic [2:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

endpackage

// File: rtl/tmr_mismatch_detect.sv
// rtl/tmr_mismatch_detect.sv - combinational majority vote and per-replica mismatch flags
//
// Purpose: reusable LTMR helper; votes three replicas bit by bit and flags
// every replica whose value differs from the voted value in any bit.
// Ports:
//    i_rep_0..i_rep_2  replica values
//    o_maj             bitwise majority of the three replicas
//    o_mm              o_mm[i] = replica i differs from o_maj

module tmr_mismatch_detect
   import tmr_pkg::*;
#(
   parameter int WIDTH = 1
)(
   input  logic [WIDTH-1:0] i_rep_0,
   input  logic [WIDTH-1:0] i_rep_1,
   input  logic [WIDTH-1:0] i_rep_2,
   output logic [WIDTH-1:0] o_maj,
   output logic [2:0]       o_mm
);

   for (genvar b = 0; b < WIDTH; b++) begin : g_vote
      assign o_maj[b] = majority(i_rep_0[b], i_rep_1[b], i_rep_2[b]);
   end

   assign o_mm[0] = |(i_rep_0 ^ o_maj);
   assign o_mm[1] = |(i_rep_1 ^ o_maj);
   assign o_mm[2] = |(i_rep_2 ^ o_maj);

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// rtl/tmr_scrub_ctrl.sv - scrub and fault-management controller for a local-TMR register group
//
// Purpose: watches three replica outputs, requests reloads of the voted value
// into disagreeing replicas, retires replicas that keep refusing a reload and
// reports every episode as an event over a valid/ready channel.
// Ports:
//    clk, rst_n          clock (rising edge), asynchronous active-low reset
//    rep_q_0..rep_q_2    replica Q values
//    clr                 sync pulse clearing err_cnt, persist counters, fail_mask
//    scrub_en            per-replica reload enable, non-zero only in SCRUB
//    fail_mask           sticky per-replica failed flags
//    err_cnt             saturating count of detected mismatch events
//    evt_valid/evt_ready event handshake
//    evt_kind/evt_mask   event payload, held stable while evt_valid is pending
// Build option: TMR_SCRUB_PERIODIC_EN adds a periodic scrub of all healthy
// replicas after SCRUB_PERIOD quiet cycles in MONITOR.

module tmr_scrub_ctrl
   import tmr_pkg::*;
#(
   parameter int WIDTH         = 1,
   parameter int CNT_W         = 8,
   parameter int PERSIST_LIMIT = 3,
   parameter int SCRUB_PERIOD  = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] rep_q_0,
   input  logic [WIDTH-1:0] rep_q_1,
   input  logic [WIDTH-1:0] rep_q_2,
   input  logic             clr,
   output logic [2:0]       scrub_en,
   output logic [2:0]       fail_mask,
   output logic [CNT_W-1:0] err_cnt,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [1:0]       evt_kind,
   output logic [2:0]       evt_mask
);

   localparam int P_W = $clog2(PERSIST_LIMIT + 1);

   // Registers
   tmr_state_t          r_state;
   logic [2:0]          r_tgt;
   logic [2:0]          r_fail_mask;
   logic [2:0][P_W-1:0] r_persist;
   logic [CNT_W-1:0]    r_err_cnt;
   tmr_evt_kind_t       r_evt_kind;
   logic [2:0]          r_evt_mask;
   logic                r_pf;          // a replica was retired earlier in this episode

   // Combinational
   logic [WIDTH-1:0]    w_maj_unused;  // voted value is consumed by the datapath, not here
   logic [2:0]          w_mm;
   logic [2:0]          w_act;
   logic                w_uncorr;
   tmr_state_t          w_state_nxt;
   logic [2:0]          w_tgt_nxt;
   logic                w_err_inc;
   logic [2:0]          w_fail_set;
   logic [2:0]          w_retry;
   logic [2:0]          w_persist_inc;
   logic [2:0]          w_persist_clr;
   logic                w_pf_any;
   logic                w_report;
   logic                w_evt_load;
   tmr_evt_kind_t       w_evt_kind_nxt;
   logic [2:0]          w_evt_mask_nxt;
   logic                w_pf_nxt;
   logic [2:0]          w_scrub_en;

`ifdef TMR_SCRUB_PERIODIC_EN
   localparam int PC_W = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
   logic [PC_W-1:0]     r_per_cnt;
   logic                r_periodic;    // current episode was started by the period timer
   logic                w_periodic_nxt;
   logic                w_per_hit;
`else
   localparam int SCRUB_PERIOD_UNUSED = SCRUB_PERIOD;
`endif

   tmr_mismatch_detect #(
      .WIDTH (WIDTH)
   ) u_detect (
      .i_rep_0 (rep_q_0),
      .i_rep_1 (rep_q_1),
      .i_rep_2 (rep_q_2),
      .o_maj   (w_maj_unused),
      .o_mm    (w_mm)
   );

   assign w_act = w_mm & ~r_fail_mask;

   // Two disagreeing replicas cannot be outvoted; with two replicas retired the
   // survivor cannot be trusted either, so any mismatch is uncorrectable.
   assign w_uncorr = (popcount3(w_mm) >= 2'd2) ||
                     ((popcount3(r_fail_mask) >= 2'd2) && (w_mm != 3'b000));

`ifdef TMR_SCRUB_PERIODIC_EN
   assign w_per_hit = (r_per_cnt == PC_W'(SCRUB_PERIOD - 1));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_MONITOR;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_tgt_nxt      = r_tgt;
      w_err_inc      = 1'b0;
      w_fail_set     = 3'b000;
      w_retry        = 3'b000;
      w_persist_inc  = 3'b000;
      w_persist_clr  = 3'b000;
      w_pf_any       = r_pf;
      w_report       = 1'b1;
      w_evt_load     = 1'b0;
      w_evt_kind_nxt = r_evt_kind;
      w_evt_mask_nxt = r_evt_mask;
      w_pf_nxt       = r_pf;
      w_scrub_en     = 3'b000;
`ifdef TMR_SCRUB_PERIODIC_EN
      w_periodic_nxt = r_periodic;
`endif

      case (r_state)
         ST_MONITOR: begin
            w_pf_nxt = 1'b0;
`ifdef TMR_SCRUB_PERIODIC_EN
            w_periodic_nxt = 1'b0;
`endif
            if (w_uncorr) begin
               w_err_inc      = 1'b1;
               w_evt_load     = 1'b1;
               w_evt_kind_nxt = EVT_UNCORR;
               w_evt_mask_nxt = w_mm;
               w_state_nxt    = ST_REPORT;
            end else if (w_act != 3'b000) begin
               w_err_inc   = 1'b1;
               w_tgt_nxt   = w_act;
               w_state_nxt = ST_SCRUB;
            end
`ifdef TMR_SCRUB_PERIODIC_EN
            else if (w_per_hit && (r_fail_mask != 3'b111)) begin
               w_tgt_nxt      = ~r_fail_mask;
               w_periodic_nxt = 1'b1;
               w_state_nxt    = ST_SCRUB;
            end
`endif
         end

         ST_SCRUB: begin
            w_scrub_en  = r_tgt;
            w_state_nxt = ST_CHECK;
         end

         ST_CHECK: begin
            for (int i = 0; i < 3; i++) begin
               if (r_tgt[i]) begin
                  if (!w_mm[i]) begin
                     w_persist_clr[i] = 1'b1;
                  end else begin
                     w_persist_inc[i] = 1'b1;
                     if (int'(r_persist[i]) + 1 >= PERSIST_LIMIT) w_fail_set[i] = 1'b1;
                     else                                         w_retry[i]    = 1'b1;
                  end
               end
            end
            w_pf_any = r_pf | (|w_fail_set);
            if (|w_retry) begin
               // A replica retired in this check is dropped from further reloads.
               w_tgt_nxt   = r_tgt & ~w_fail_set;
               w_pf_nxt    = w_pf_any;
               w_state_nxt = ST_SCRUB;
            end else begin
`ifdef TMR_SCRUB_PERIODIC_EN
               w_report = !r_periodic || w_pf_any;
`endif
               if (w_report) begin
                  w_evt_load     = 1'b1;
                  w_evt_kind_nxt = w_pf_any ? EVT_PERSIST_FAIL : EVT_CORRECTED;
                  w_evt_mask_nxt = r_tgt;
                  w_state_nxt    = ST_REPORT;
               end else begin
                  w_state_nxt    = ST_MONITOR;
               end
            end
         end

         ST_REPORT: begin
            if (evt_ready) w_state_nxt = ST_MONITOR;
         end

         default: w_state_nxt = ST_MONITOR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tgt       <= 3'b000;
         r_pf        <= 1'b0;
         r_evt_kind  <= EVT_CORRECTED;
         r_evt_mask  <= 3'b000;
         r_err_cnt   <= '0;
         r_fail_mask <= 3'b000;
         r_persist   <= '0;
      end else begin
         r_tgt <= w_tgt_nxt;
         r_pf  <= w_pf_nxt;
         if (w_evt_load) begin
            r_evt_kind <= w_evt_kind_nxt;
            r_evt_mask <= w_evt_mask_nxt;
         end
         // clr wins over every counter/mask update in the same cycle but leaves
         // the FSM and any pending event alone.
         if (clr) begin
            r_err_cnt   <= '0;
            r_fail_mask <= 3'b000;
            r_persist   <= '0;
         end else begin
            if (w_err_inc && (r_err_cnt != {CNT_W{1'b1}})) r_err_cnt <= r_err_cnt + 1'b1;
            r_fail_mask <= r_fail_mask | w_fail_set;
            for (int i = 0; i < 3; i++) begin
               if (w_persist_clr[i])      r_persist[i] <= '0;
               else if (w_persist_inc[i]) r_persist[i] <= r_persist[i] + P_W'(1);
            end
         end
      end
   end

`ifdef TMR_SCRUB_PERIODIC_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_per_cnt  <= '0;
         r_periodic <= 1'b0;
      end else begin
         r_periodic <= w_periodic_nxt;
         // The timer only advances across consecutive quiet MONITOR cycles.
         if ((r_state != ST_MONITOR) || (w_state_nxt != ST_MONITOR) || w_per_hit)
            r_per_cnt <= '0;
         else
            r_per_cnt <= r_per_cnt + PC_W'(1);
      end
   end
`endif

   assign scrub_en  = w_scrub_en;
   assign fail_mask = r_fail_mask;
   assign err_cnt   = r_err_cnt;
   assign evt_valid = (r_state == ST_REPORT);
   assign evt_kind  = r_evt_kind;
   assign evt_mask  = r_evt_mask;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// tb/tb_tmr_scrub_ctrl.sv - self-checking bench for tmr_scrub_ctrl with a behavioural replica model

module tb_tmr_scrub_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] rep [3];
   logic       clr;
   logic       evt_ready;
   logic [2:0] scrub_en;
   logic [2:0] fail_mask;
   logic [7:0] err_cnt;
   logic       evt_valid;
   logic [1:0] evt_kind;
   logic [2:0] evt_mask;

   logic [2:0] stuck;
   logic [3:0] stuck_val [3];

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [3:0] r0, r1, r2;
      logic [2:0] stk;
      logic [2:0] se;
      int         att;
      logic [1:0] kind;
      logic [2:0] mask;
      int         lat;
      logic [2:0] fail;
   } vec_t;

   vec_t vecs [7];

   tmr_scrub_ctrl #(
      .WIDTH         (4),
      .CNT_W         (8),
      .PERSIST_LIMIT (3),
      .SCRUB_PERIOD  (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rep_q_0   (rep[0]),
      .rep_q_1   (rep[1]),
      .rep_q_2   (rep[2]),
      .clr       (clr),
      .scrub_en  (scrub_en),
      .fail_mask (fail_mask),
      .err_cnt   (err_cnt),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_kind  (evt_kind),
      .evt_mask  (evt_mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // One clock; the replica model reloads the voted value where scrub_en was set
   // during the cycle, except for stuck replicas.
   task automatic step();
      logic [2:0] se;
      logic [3:0] v;
      se = scrub_en;
      v  = (rep[0] & rep[1]) | (rep[0] & rep[2]) | (rep[1] & rep[2]);
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         if (stuck[i])   rep[i] = stuck_val[i];
         else if (se[i]) rep[i] = v;
      end
   endtask

   task automatic wait_evt(output int lat, output int att, output logic [2:0] first_se);
      lat = -1; att = 0; first_se = 3'b000;
      for (int c = 1; c <= 40; c++) begin
         step();
         if (scrub_en != 3'b000) begin
            if (att == 0) first_se = scrub_en;
            att++;
         end
         if (evt_valid) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic accept_restore();
      evt_ready = 1'b1;
      stuck     = 3'b000;
      rep[0] = 4'd5; rep[1] = 4'd5; rep[2] = 4'd5;
      step();
      evt_ready = 1'b0;
   endtask

   task automatic clr_pulse();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic inject_stuck(input int idx, input logic [3:0] val);
      stuck[idx]     = 1'b1;
      stuck_val[idx] = val;
      rep[idx]       = val;
   endtask

   initial begin
      int         lat, att;
      logic [2:0] fse;
      bit         bad;
      logic [1:0] k0;
      logic [2:0] m0;

      //            r0    r1     r2     stuck   se      att kind   mask    lat fail
      vecs[0] = '{4'd5, 4'd4,  4'd5,  3'b000, 3'b010, 1, 2'd0, 3'b010, 3, 3'b000};
      vecs[1] = '{4'd5, 4'd5,  4'd0,  3'b100, 3'b100, 3, 2'd1, 3'b100, 7, 3'b100};
      vecs[2] = '{4'd1, 4'd2,  4'd4,  3'b000, 3'b000, 0, 2'd2, 3'b111, 1, 3'b000};
      vecs[3] = '{4'd7, 4'd5,  4'd5,  3'b000, 3'b001, 1, 2'd0, 3'b001, 3, 3'b000};
      vecs[4] = '{4'd0, 4'd5,  4'd5,  3'b001, 3'b001, 3, 2'd1, 3'b001, 7, 3'b001};
      vecs[5] = '{4'd5, 4'd5,  4'd13, 3'b000, 3'b100, 1, 2'd0, 3'b100, 3, 3'b000};
      vecs[6] = '{4'd0, 4'd15, 4'd0,  3'b000, 3'b010, 1, 2'd0, 3'b010, 3, 3'b000};

      rst_n = 1'b0; clr = 1'b0; evt_ready = 1'b0; stuck = 3'b000;
      for (int i = 0; i < 3; i++) begin rep[i] = 4'd5; stuck_val[i] = 4'd0; end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_scrub_en",  32'(scrub_en),  0);
      chk("rst_evt_valid", 32'(evt_valid), 0);
      chk("rst_err_cnt",   32'(err_cnt),   0);
      chk("rst_fail_mask", 32'(fail_mask), 0);
      chk("rst_evt_kind",  32'(evt_kind),  0);
      chk("rst_evt_mask",  32'(evt_mask),  0);
      rst_n = 1'b1;

`ifdef TMR_SCRUB_PERIODIC_EN
      begin
         int first, second;
         first = -1; second = -1; bad = 1'b0;
         for (int c = 1; c <= 40; c++) begin
            step();
            if (scrub_en == 3'b111) begin
               if (first < 0) first = c;
               else if (second < 0) second = c;
            end
            if (evt_valid) bad = 1'b1;
         end
         chk("per_first_scrub",  32'(first),  16);
         chk("per_second_scrub", 32'(second), 34);
         chk("per_no_evt",       32'(bad),    0);
         chk("per_err_cnt",      32'(err_cnt), 0);
      end
`else
      bad = 1'b0;
      for (int c = 0; c < 50; c++) begin
         step();
         if (scrub_en != 3'b000 || evt_valid) bad = 1'b1;
      end
      chk("idle_quiet",   32'(bad),     0);
      chk("idle_err_cnt", 32'(err_cnt), 0);
`endif

      // Table-driven fault episodes, each from a cleared state.
      for (int v = 0; v < 7; v++) begin
         rep[0] = vecs[v].r0; rep[1] = vecs[v].r1; rep[2] = vecs[v].r2;
         stuck = vecs[v].stk;
         for (int i = 0; i < 3; i++) stuck_val[i] = rep[i];
         wait_evt(lat, att, fse);
         chk($sformatf("v%0d_evt_seen", v), 32'(lat > 0),   1);
         chk($sformatf("v%0d_first_se", v), 32'(fse),       32'(vecs[v].se));
         chk($sformatf("v%0d_attempts", v), 32'(att),       32'(vecs[v].att));
         chk($sformatf("v%0d_latency",  v), 32'(lat),       32'(vecs[v].lat));
         chk($sformatf("v%0d_kind",     v), 32'(evt_kind),  32'(vecs[v].kind));
         chk($sformatf("v%0d_mask",     v), 32'(evt_mask),  32'(vecs[v].mask));
         chk($sformatf("v%0d_fail",     v), 32'(fail_mask), 32'(vecs[v].fail));
         chk($sformatf("v%0d_err_cnt",  v), 32'(err_cnt),   1);
         accept_restore();
         chk($sformatf("v%0d_evt_done", v), 32'(evt_valid), 0);
         clr_pulse();
      end

      // Retired replica 2 stays stuck: no further scrub, no events, no count.
      inject_stuck(2, 4'd0);
      wait_evt(lat, att, fse);
      chk("stk2_kind", 32'(evt_kind),  1);
      chk("stk2_fail", 32'(fail_mask), 3'b100);
      evt_ready = 1'b1; step(); evt_ready = 1'b0;
      bad = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (scrub_en != 3'b000 || evt_valid) bad = 1'b1;
      end
      chk("stk2_no_rescrub", 32'(bad),     0);
      chk("stk2_err_cnt",    32'(err_cnt), 1);
      stuck = 3'b000; rep[2] = 4'd5;

      // Retire replica 0 as well; with two retired a lone mismatch is UNCORR.
      inject_stuck(0, 4'd0);
      wait_evt(lat, att, fse);
      chk("stk0_fail", 32'(fail_mask), 3'b101);
      accept_restore();
      rep[1] = 4'd4;
      wait_evt(lat, att, fse);
      chk("two_fail_lat",  32'(lat),      1);
      chk("two_fail_att",  32'(att),      0);
      chk("two_fail_kind", 32'(evt_kind), 2);
      chk("two_fail_mask", 32'(evt_mask), 3'b010);
      chk("two_fail_err",  32'(err_cnt),  3);
      accept_restore();

      // Saturate err_cnt with repeated uncorrectable events.
      for (int n = 0; n < 260; n++) begin
         rep[0] = 4'd4;
         wait_evt(lat, att, fse);
         accept_restore();
      end
      chk("sat_err_cnt", 32'(err_cnt), 255);

      // clr together with a fresh fault: clear wins, event still raised.
      clr = 1'b1; rep[1] = 4'd4;
      step();
      clr = 1'b0;
      chk("clr_err_cnt",   32'(err_cnt),   0);
      chk("clr_fail_mask", 32'(fail_mask), 0);
      chk("clr_evt_valid", 32'(evt_valid), 1);
      chk("clr_evt_kind",  32'(evt_kind),  2);
      accept_restore();

      // Uncorrectable event held by back-pressure keeps a stable payload.
      rep[0] = 4'd1; rep[1] = 4'd2; rep[2] = 4'd4;
      wait_evt(lat, att, fse);
      k0 = evt_kind; m0 = evt_mask; bad = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (!evt_valid || evt_kind != k0 || evt_mask != m0 || scrub_en != 3'b000) bad = 1'b1;
      end
      chk("hold_kind",   32'(k0),  2);
      chk("hold_mask",   32'(m0),  3'b111);
      chk("hold_stable", 32'(bad), 0);
      accept_restore();
      chk("hold_done", 32'(evt_valid), 0);
      step();
      chk("hold_monitor_quiet", 32'(evt_valid | (|scrub_en)), 0);

      // clr in the final CHECK cycle blocks the fail_mask set but keeps the event.
      inject_stuck(2, 4'd0);
      for (int c = 1; c <= 6; c++) begin
         step();
         if (c == 5) chk("cc_third_scrub", 32'(scrub_en), 3'b100);
      end
      chk("cc_in_check", 32'(evt_valid | (|scrub_en)), 0);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("cc_evt_valid", 32'(evt_valid), 1);
      chk("cc_evt_kind",  32'(evt_kind),  1);
      chk("cc_evt_mask",  32'(evt_mask),  3'b100);
      chk("cc_fail_mask", 32'(fail_mask), 0);
      chk("cc_err_cnt",   32'(err_cnt),   0);
      accept_restore();

      // Reset asserted during SCRUB aborts at once.
      rep[1] = 4'd4;
      step();
      chk("rs_scrub_en", 32'(scrub_en), 3'b010);
      chk("rs_err_pre",  32'(err_cnt),  1);
      rst_n = 1'b0;
      #1;
      chk("rs_scrub_en_rst", 32'(scrub_en),  0);
      chk("rs_evt_rst",      32'(evt_valid), 0);
      chk("rs_err_rst",      32'(err_cnt),   0);
      chk("rs_fail_rst",     32'(fail_mask), 0);
      rep[1] = 4'd5;
      step();
      rst_n = 1'b1;
      step();
      chk("rs_after_quiet", 32'(evt_valid | (|scrub_en)), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tmr_scrub_ctrl.md
Name: tmr_scrub_ctrl

Overview:
Scrub and fault-management controller for a local-TMR register group: three replica flops feeding a majority voter.
- Watches the three replica outputs and detects which replica disagrees with the bitwise majority.
- Drives per-replica reload enables so the voted value is written back into faulty replicas.
- Tracks persistent faults and reports events over a valid/ready channel.
- Sits beside the LTMR register/voter datapath. The datapath muxes voted value into replica D when scrub_en[i]=1.

Parameters:
WIDTH, 1, bit width of each replica
CNT_W, 8, width of error counter (saturating)
PERSIST_LIMIT, 3, consecutive failed scrubs of a replica before it is marked failed
SCRUB_PERIOD, 16, cycles between periodic scrubs (only with optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rep_q_0  in  WIDTH  replica 0 Q
rep_q_1  in  WIDTH  replica 1 Q
rep_q_2  in  WIDTH  replica 2 Q
clr  in  1  sync pulse: clear err_cnt, persist counters, fail_mask
scrub_en  out  3  per-replica reload enable (load voted value next edge)
fail_mask  out  3  sticky: replica i declared failed
err_cnt  out  CNT_W  total detected mismatch events, saturating
evt_valid  out  1  event pending
evt_ready  in  1  consumer accepts event
evt_kind  out  2  0=CORRECTED, 1=PERSIST_FAIL, 2=UNCORR, 3=reserved
evt_mask  out  3  replicas involved in event

Behaviour:
Reset values:
- All outputs reset to 0; state=MONITOR.
- Persist counters reset to 0.

Detection (combinational):
- maj = bitwise majority of the three replicas.
- mm[i] = |(rep_q_i ^ maj).
- act = mm & ~fail_mask.

FSM states: MONITOR, SCRUB, CHECK, REPORT.
- MONITOR:
  - If popcount(mm) >= 2: err_cnt+1, latch evt_kind=UNCORR and evt_mask=mm, go to REPORT. No scrub.
  - Else if act != 0: err_cnt+1, latch tgt=act, go to SCRUB.
  - Else stay.
- SCRUB (1 cycle): scrub_en=tgt. Replicas load the voted value at the end of this cycle. Go to CHECK.
- CHECK (1 cycle): for each i in tgt:
  - If mm[i]=0: clear persist[i]; event CORRECTED.
  - If mm[i]=1: persist[i]+1. If persist[i] reaches PERSIST_LIMIT, set fail_mask[i] and event PERSIST_FAIL; otherwise return to SCRUB with the same tgt (retry).
  - PERSIST_FAIL takes precedence over CORRECTED in evt_kind. evt_mask=tgt.
  - Go to REPORT once no retry is pending.
- REPORT:
  - evt_valid=1. evt_kind and evt_mask stay stable until evt_valid && evt_ready.
  - On handshake: evt_valid=0, go to MONITOR.
  - Mismatches arising during REPORT are not lost: MONITOR re-detects them on return.

Latency:
- Mismatch visible in cycle N → scrub_en asserted in N+1 → CHECK in N+2 → evt_valid in N+3 (no retry).
- Each retry adds 2 cycles.

Boundary rules:
- err_cnt saturates at 2^CNT_W-1.
- clr has priority over same-cycle increments and over fail_mask set. clr does not change state and does not drop a pending event.
- Replicas with fail_mask set are never scrubbed. Their mismatch does not trigger SCRUB but still counts toward the UNCORR popcount.
- With two or more fail_mask bits set, any mismatch yields UNCORR.
- scrub_en is 0 in every state except SCRUB.
- Reset asserted mid-operation aborts immediately: scrub_en=0, evt_valid=0, all counters cleared.

Optional Feature:
TMR_SCRUB_PERIODIC_EN:
- When defined: a free-running counter counts in MONITOR only. When it reaches SCRUB_PERIOD-1 with act=0, the FSM enters SCRUB with tgt=~fail_mask. err_cnt is not incremented and the counter resets.
- In CHECK after a periodic scrub, REPORT is entered only if a persist event occurred; otherwise the FSM returns to MONITOR.
- A detected mismatch in the same cycle takes precedence over the periodic scrub and also resets the counter.
- When undefined: no periodic counter; SCRUB_PERIOD is unused.

Decomposition:
- Package tmr_pkg:
  - state enum (MONITOR/SCRUB/CHECK/REPORT)
  - evt_kind enum with values above
  - majority function
  - popcount3 function
- One sub-module tmr_mismatch_detect: purely combinational; inputs three replicas, outputs maj and mm[2:0]. It is reusable by other LTMR blocks.

Test Plan:
- WIDTH=4, replicas 5/5/5 for 50 cycles → scrub_en=0, evt_valid=0, err_cnt=0.
- Flip rep_q_1 to 4 at cycle N; replica reloads 5 on scrub_en[1] → scrub_en=3'b010 at N+1; evt_valid at N+3 with kind=0, mask=3'b010; err_cnt=1.
- rep_q_2 stuck at 0, others 5 → three scrub attempts on replica 2, then fail_mask=3'b100, evt kind=1 mask=3'b100. A further stuck mismatch causes no scrub.
- Replicas 1/2/4 → evt kind=2, mask=3'b111, no scrub_en pulse. Hold evt_ready=0 for 10 cycles → payload stable; accept → back to MONITOR.
- Set err_cnt to 255 via repeated faults with CNT_W=8 → stays 255. Pulse clr with a simultaneous fault → err_cnt=0, fail_mask=0.
- With TMR_SCRUB_PERIODIC_EN and SCRUB_PERIOD=16, no faults → scrub_en=3'b111 every 18 cycles, err_cnt=0, no events. Assert rst_n low during SCRUB → all outputs 0 immediately.
